// File: rtl/jleightcap_pkg.sv
// jleightcap_pkg: shared types and constants for the instruction feeder
package jleightcap_pkg;
    localparam int INSTR_W = 6;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 6'b000000;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} feeder_state_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/jleightcap_instr_fifo.sv
// jleightcap_instr_fifo: single-clock circular FIFO with occupancy count
module jleightcap_instr_fifo
    import jleightcap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    // storage needs no reset: pointers and count alone define valid contents
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    // pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/jleightcap_instr_feeder.sv
// jleightcap_instr_feeder: buffers a program, streams it to the core, captures the result
module jleightcap_instr_feeder
    import jleightcap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int INSTR_W = jleightcap_pkg::INSTR_W,
    parameter int RESULT_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [INSTR_W-1:0]        wr_data,
    output logic                      wr_ready,
    input  logic                      start,
    output logic [INSTR_W-1:0]        instr,
    output logic                      instr_valid,
    input  logic [7:0]                core_out,
    output logic                      res_valid,
    output logic [7:0]                res_data,
    output logic                      busy,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int DW = RESULT_LAT > 1 ? $clog2(RESULT_LAT) : 1;
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);
    feeder_state_t state, state_n;
    logic [INSTR_W-1:0] head, instr_n;
    logic [7:0] res_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic iv_n, rv_n, push, pop, full, empty, wr_fire;

    jleightcap_instr_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(wr_data),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    assign busy = state != IDLE;
    assign wr_ready = state == IDLE && !full;
    assign wr_fire = wr_valid && wr_ready;

    // sequencer: a write landing on an empty buffer with start bypasses storage
    always_comb begin
        state_n = state;
        instr_n = NOP;
        iv_n = 1'b0;
        rv_n = 1'b0;
        res_n = res_data;
        dcnt_n = dcnt;
        push = wr_fire;
        pop = 1'b0;
        case (state)
            IDLE: if (start && (wr_fire || !empty)) begin
                state_n = ISSUE;
                iv_n = 1'b1;
                instr_n = empty ? wr_data : head;
                pop = !empty;
                push = wr_fire && !empty;
            end
            ISSUE: if (!empty) begin
                pop = 1'b1;
                iv_n = 1'b1;
                instr_n = head;
            end else begin
                dcnt_n = DW'(RESULT_LAT - 1);
                state_n = DRAIN;
            end
            DRAIN: if (dcnt == '0) begin
                res_n = core_out;
                rv_n = 1'b1;
                state_n = IDLE;
            end else begin
                dcnt_n = dcnt - DW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            instr <= NOP;
            instr_valid <= 1'b0;
            res_valid <= 1'b0;
            res_data <= 8'h00;
            dcnt <= '0;
        end else begin
            state <= state_n;
            instr <= instr_n;
            instr_valid <= iv_n;
            res_valid <= rv_n;
            res_data <= res_n;
            dcnt <= dcnt_n;
        end
    end
endmodule
